// File: rtl/readout_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : readout_sequencer
// Brief   : Walks the pixel array row by row and column by column, waits for
//           the select lines to settle, then streams each pixel over valid/ready.
// Revision: 1.0
// ============================================================================
module readout_sequencer #(
    parameter int PIXEL_ARRAY_HEIGHT = 2,
    parameter int PIXEL_ARRAY_WIDTH  = 2,
    parameter int PIXEL_BITS         = 8,
    parameter int COL_BITS           = 1,
    parameter int ROW_SETTLE         = 5,
    parameter int COL_SETTLE         = 1,
    parameter int SETTLE_BITS        = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic [PIXEL_ARRAY_HEIGHT-1:0] p_row_select,
    output logic [COL_BITS-1:0]           p_col_index,
    input  logic [PIXEL_BITS-1:0]         p_pixel_data,
    output logic [PIXEL_BITS-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sof,
    output logic                          out_eol,
    output logic                          out_eof
);

    localparam int ROW_BITS = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;

    localparam logic [ROW_BITS-1:0]           c_LAST_ROW = ROW_BITS'(PIXEL_ARRAY_HEIGHT - 1);
    localparam logic [COL_BITS-1:0]           c_LAST_COL = COL_BITS'(PIXEL_ARRAY_WIDTH - 1);
    localparam logic [SETTLE_BITS-1:0]        c_ROW_TGT  = SETTLE_BITS'(ROW_SETTLE - 1);
    localparam logic [SETTLE_BITS-1:0]        c_COL_TGT  = SETTLE_BITS'(COL_SETTLE - 1);
    localparam logic [PIXEL_ARRAY_HEIGHT-1:0] c_ROW0_SEL = PIXEL_ARRAY_HEIGHT'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [ROW_BITS-1:0]             row_q, row_d;
    logic [COL_BITS-1:0]             col_q, col_d;
    logic [SETTLE_BITS-1:0]          cnt_q, cnt_d;
    // Holds the settle length minus one, so the compare needs no subtractor
    logic [SETTLE_BITS-1:0]          tgt_q, tgt_d;
    logic [PIXEL_ARRAY_HEIGHT-1:0]   row_sel_q, row_sel_d;
    logic [PIXEL_BITS-1:0]           data_q, data_d;
    logic                            valid_q, valid_d;
    logic                            sof_q, sof_d;
    logic                            eol_q, eol_d;
    logic                            eof_q, eof_d;
    logic                            done_q, done_d;

    logic                            w_last_row;
    logic                            w_last_col;

    assign w_last_row = (row_q == c_LAST_ROW);
    assign w_last_col = (col_q == c_LAST_COL);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        row_sel_d = row_sel_q;
        data_d    = data_q;
        valid_d   = valid_q;
        sof_d     = sof_q;
        eol_d     = eol_q;
        eof_d     = eof_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d   = S_SETTLE;
                    row_d     = '0;
                    col_d     = '0;
                    cnt_d     = '0;
                    tgt_d     = c_ROW_TGT;
                    row_sel_d = c_ROW0_SEL;
                end
            end
            S_SETTLE: begin
                if (cnt_q == tgt_q) begin
                    state_d = S_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SETTLE_BITS'(1);
                end
            end
            S_SAMPLE: begin
                state_d = S_OUTPUT;
                data_d  = p_pixel_data;
                valid_d = 1'b1;
                sof_d   = (row_q == '0) && (col_q == '0);
                eol_d   = w_last_col;
                eof_d   = w_last_col && w_last_row;
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    sof_d   = 1'b0;
                    eol_d   = 1'b0;
                    eof_d   = 1'b0;
                    cnt_d   = '0;
                    if (w_last_col && w_last_row) begin
                        state_d   = S_IDLE;
                        done_d    = 1'b1;
                        row_d     = '0;
                        col_d     = '0;
                        row_sel_d = '0;
                    end else if (w_last_col) begin
                        state_d   = S_SETTLE;
                        row_d     = row_q + ROW_BITS'(1);
                        col_d     = '0;
                        row_sel_d = row_sel_q << 1;
                        tgt_d     = c_ROW_TGT;
                    end else begin
                        state_d = S_SETTLE;
                        col_d   = col_q + COL_BITS'(1);
                        tgt_d   = c_COL_TGT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything above and drops valid without a handshake
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            row_d     = '0;
            col_d     = '0;
            cnt_d     = '0;
            tgt_d     = '0;
            row_sel_d = '0;
            data_d    = '0;
            valid_d   = 1'b0;
            sof_d     = 1'b0;
            eol_d     = 1'b0;
            eof_d     = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            cnt_q     <= '0;
            tgt_q     <= '0;
            row_sel_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            eof_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            tgt_q     <= tgt_d;
            row_sel_q <= row_sel_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
            eof_q     <= eof_d;
            done_q    <= done_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign p_row_select = row_sel_q;
    assign p_col_index  = col_q;
    assign out_data     = data_q;
    assign out_valid    = valid_q;
    assign out_sof      = sof_q;
    assign out_eol      = eol_q;
    assign out_eof      = eof_q;

endmodule
`default_nettype wire

// File: tb/tb_readout_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_readout_sequencer
// Brief   : Scoreboard bench for readout_sequencer: a 2x2 default instance and
//           a 3x1 instance with a short row settle.
// Revision: 1.0
// ============================================================================
module tb_readout_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    int   cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- DUT A: 2x2 defaults ----------------
    logic       a_start = 1'b0, a_abort = 1'b0, a_ready = 1'b0;
    logic       a_busy, a_done, a_valid, a_sof, a_eol, a_eof;
    logic [1:0] a_row_sel;
    logic [0:0] a_col;
    logic [7:0] a_pix, a_data;
    logic       a_scr_en = 1'b0;
    logic [7:0] a_scr    = 8'h00;

    // Pixel array model: value is {row, col} in nibbles unless scrambled
    assign a_pix = a_scr_en ? a_scr : {3'b000, a_row_sel[1], 3'b000, a_col};

    readout_sequencer u_dut_a (
        .clk          (clk),
        .reset        (rst_n),
        .start        (a_start),
        .abort        (a_abort),
        .busy         (a_busy),
        .done         (a_done),
        .p_row_select (a_row_sel),
        .p_col_index  (a_col),
        .p_pixel_data (a_pix),
        .out_data     (a_data),
        .out_valid    (a_valid),
        .out_ready    (a_ready),
        .out_sof      (a_sof),
        .out_eol      (a_eol),
        .out_eof      (a_eof)
    );

    // ---------------- DUT B: 3x1, ROW_SETTLE=2 ----------------
    logic       b_start = 1'b0, b_abort = 1'b0, b_ready = 1'b0;
    logic       b_busy, b_done, b_valid, b_sof, b_eol, b_eof;
    logic [2:0] b_row_sel;
    logic [0:0] b_col;
    logic [7:0] b_pix, b_data;
    logic [3:0] b_row_idx;

    assign b_row_idx = b_row_sel[2] ? 4'd2 : (b_row_sel[1] ? 4'd1 : 4'd0);
    assign b_pix     = {b_row_idx, 4'h0};

    readout_sequencer #(
        .PIXEL_ARRAY_HEIGHT (3),
        .PIXEL_ARRAY_WIDTH  (1),
        .PIXEL_BITS         (8),
        .COL_BITS           (1),
        .ROW_SETTLE         (2),
        .COL_SETTLE         (1),
        .SETTLE_BITS        (8)
    ) u_dut_b (
        .clk          (clk),
        .reset        (rst_n),
        .start        (b_start),
        .abort        (b_abort),
        .busy         (b_busy),
        .done         (b_done),
        .p_row_select (b_row_sel),
        .p_col_index  (b_col),
        .p_pixel_data (b_pix),
        .out_data     (b_data),
        .out_valid    (b_valid),
        .out_ready    (b_ready),
        .out_sof      (b_sof),
        .out_eol      (b_eol),
        .out_eof      (b_eof)
    );

    // ---------------- scoreboards ----------------
    typedef struct packed {
        logic [1:0] rs;
        logic [0:0] col;
        logic [7:0] data;
        logic       sof;
        logic       eol;
        logic       eof;
    } a_pix_t;

    typedef struct packed {
        logic [2:0] rs;
        logic [7:0] data;
        logic       sof;
        logic       eol;
        logic       eof;
    } b_pix_t;

    a_pix_t qa[$];
    b_pix_t qb[$];
    int a_hs = 0, a_last_hs = 0, a_done_cnt = 0;
    int b_hs = 0, b_last_hs = 0, b_done_cnt = 0;

    function automatic a_pix_t mk_a(input logic [1:0] rs, input logic c, input logic [7:0] d,
                                    input logic s, input logic l, input logic f);
        mk_a = {rs, c, d, s, l, f};
    endfunction

    function automatic b_pix_t mk_b(input logic [2:0] rs, input logic [7:0] d,
                                    input logic s, input logic l, input logic f);
        mk_b = {rs, d, s, l, f};
    endfunction

    task automatic push_a_frame;
        qa.push_back(mk_a(2'b01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        qa.push_back(mk_a(2'b01, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0));
        qa.push_back(mk_a(2'b10, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0));
        qa.push_back(mk_a(2'b10, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1));
    endtask

    // Handshake edge is the posedge following this negedge, hence cyc+1
    task automatic a_monitor;
        a_pix_t e, o;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && a_done === 1'b1) a_done_cnt++;
            if (rst_n === 1'b1 && a_valid === 1'b1 && a_ready === 1'b1) begin
                a_hs++;
                a_last_hs = cyc + 1;
                vectors++;
                o = {a_row_sel, a_col, a_data, a_sof, a_eol, a_eof};
                if (qa.size() == 0) begin
                    miscompares++;
                    $display("FAIL a_unexpected_pixel: got %h, want no pixel", o);
                end else begin
                    e = qa.pop_front();
                    if (o !== e) begin
                        miscompares++;
                        $display("FAIL a_pixel: got {rs,col,data,sof,eol,eof}=%h, want %h", o, e);
                    end
                end
            end
        end
    endtask

    task automatic b_monitor;
        b_pix_t e, o;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && b_done === 1'b1) b_done_cnt++;
            if (rst_n === 1'b1 && b_valid === 1'b1 && b_ready === 1'b1) begin
                b_hs++;
                b_last_hs = cyc + 1;
                vectors++;
                o = {b_row_sel, b_data, b_sof, b_eol, b_eof};
                if (qb.size() == 0) begin
                    miscompares++;
                    $display("FAIL b_unexpected_pixel: got %h, want no pixel", o);
                end else begin
                    e = qb.pop_front();
                    if (o !== e) begin
                        miscompares++;
                        $display("FAIL b_pixel: got {rs,data,sof,eol,eof}=%h, want %h", o, e);
                    end
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({a_busy, a_done, a_row_sel, a_col, a_data, a_valid, a_sof, a_eol, a_eof} !== '0) begin
            miscompares++;
            $display("FAIL reset_a: got outputs nonzero (busy=%b rs=%b data=%h valid=%b), want all 0",
                     a_busy, a_row_sel, a_data, a_valid);
        end
        vectors++;
        if ({b_busy, b_done, b_row_sel, b_col, b_data, b_valid, b_sof, b_eol, b_eof} !== '0) begin
            miscompares++;
            $display("FAIL reset_b: got outputs nonzero (busy=%b rs=%b valid=%b), want all 0",
                     b_busy, b_row_sel, b_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (a_busy !== 1'b0 || a_row_sel !== 2'b00 || a_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b rs=%b valid=%b, want 0 0 0", a_busy, a_row_sel, a_valid);
        end
    endtask

    task automatic test_basic_frame;
        int k, n;
        push_a_frame();
        a_ready = 1'b1; a_hs = 0; a_done_cnt = 0;
        @(negedge clk); a_start = 1'b1;
        @(posedge clk); #1; k = cyc; a_start = 1'b0;
        vectors++;
        if (a_row_sel !== 2'b01 || a_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_row_sel: got rs=%b busy=%b, want 01 1", a_row_sel, a_busy);
        end
        n = 0;
        while (a_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        vectors++;
        if (cyc != k + 6 || a_sof !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_first_valid: got edge k+%0d sof=%b, want k+6 sof=1", cyc - k, a_sof);
        end
        n = 0;
        while (a_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        vectors++;
        if (a_done !== 1'b1 || a_last_hs != k + 20 || cyc != k + 20) begin
            miscompares++;
            $display("FAIL basic_frame_end: got last_hs=k+%0d done_cycle=k+%0d, want k+20 k+20",
                     a_last_hs - k, cyc - k);
        end
        vectors++;
        if (a_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_busy_fall: got busy=%b with done, want 0", a_busy);
        end
        @(negedge clk);
        vectors++;
        if (a_done !== 1'b0 || a_done_cnt != 1 || a_hs != 4 || qa.size() != 0) begin
            miscompares++;
            $display("FAIL basic_done_pulse: got done=%b pulses=%0d hs=%0d left=%0d, want 0 1 4 0",
                     a_done, a_done_cnt, a_hs, qa.size());
        end
    endtask

    task automatic test_backpressure;
        int k, n, bad;
        push_a_frame();
        a_ready = 1'b1; a_hs = 0; a_done_cnt = 0;
        @(negedge clk); a_start = 1'b1;
        @(posedge clk); #1; k = cyc; a_start = 1'b0;
        n = 0;
        while (!(a_valid === 1'b1 && a_col === 1'b1) && n < 40) begin @(posedge clk); #1; n++; end
        vectors++;
        if (cyc != k + 9) begin
            miscompares++;
            $display("FAIL bp_r0c1_valid: got edge k+%0d, want k+9", cyc - k);
        end
        a_ready  = 1'b0;
        a_scr_en = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            a_scr = 8'($urandom);
            @(posedge clk); #1;
            if (a_data !== 8'h01 || a_valid !== 1'b1 || a_eol !== 1'b1 || a_col !== 1'b1 ||
                a_sof !== 1'b0 || a_eof !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL bp_hold: got %0d unstable cycles (last data=%h eol=%b col=%b), want 0 (01 1 1)",
                     bad, a_data, a_eol, a_col);
        end
        a_scr_en = 1'b0;
        a_ready  = 1'b1;
        n = 0;
        while (a_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        vectors++;
        if (a_last_hs != k + 30 || a_hs != 4 || qa.size() != 0) begin
            miscompares++;
            $display("FAIL bp_frame_end: got last_hs=k+%0d hs=%0d left=%0d, want k+30 4 0",
                     a_last_hs - k, a_hs, qa.size());
        end
        @(negedge clk);
    endtask

    task automatic test_abort;
        int k, n;
        push_a_frame();
        a_ready = 1'b1; a_hs = 0; a_done_cnt = 0;
        @(negedge clk); a_start = 1'b1;
        @(posedge clk); #1; k = cyc; a_start = 1'b0;
        n = 0;
        while (a_row_sel !== 2'b10 && n < 40) begin @(posedge clk); #1; n++; end
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
        vectors++;
        if (a_busy !== 1'b0 || a_row_sel !== 2'b00 || a_valid !== 1'b0 || a_col !== 1'b0 || a_hs != 2) begin
            miscompares++;
            $display("FAIL abort_state: got busy=%b rs=%b valid=%b col=%b hs=%0d, want 0 00 0 0 2",
                     a_busy, a_row_sel, a_valid, a_col, a_hs);
        end
        repeat (30) @(negedge clk);
        vectors++;
        if (a_done_cnt != 0 || a_hs != 2 || a_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_done: got done_pulses=%0d hs=%0d busy=%b, want 0 2 0",
                     a_done_cnt, a_hs, a_busy);
        end
        qa.delete();
        push_a_frame();
        a_hs = 0;
        @(negedge clk); a_start = 1'b1;
        @(posedge clk); #1; k = cyc; a_start = 1'b0;
        n = 0;
        while (a_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        vectors++;
        if (a_hs != 4 || qa.size() != 0 || a_last_hs != k + 20 || a_done_cnt != 1) begin
            miscompares++;
            $display("FAIL abort_restart: got hs=%0d left=%0d last_hs=k+%0d pulses=%0d, want 4 0 k+20 1",
                     a_hs, qa.size(), a_last_hs - k, a_done_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        int n;
        push_a_frame();
        a_ready = 1'b0; a_hs = 0; a_done_cnt = 0;
        @(negedge clk); a_start = 1'b1;
        @(posedge clk); #1; a_start = 1'b0;
        n = 0;
        while (a_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (a_valid !== 1'b0 || a_row_sel !== 2'b00 || a_busy !== 1'b0 || a_data !== 8'h00) begin
            miscompares++;
            $display("FAIL async_reset: got valid=%b rs=%b busy=%b data=%h, want 0 00 0 00",
                     a_valid, a_row_sel, a_busy, a_data);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        qa.delete();
        a_ready = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if (a_busy !== 1'b0 || a_done_cnt != 0 || a_hs != 0) begin
            miscompares++;
            $display("FAIL async_reset_idle: got busy=%b pulses=%0d hs=%0d, want 0 0 0",
                     a_busy, a_done_cnt, a_hs);
        end
    endtask

    task automatic test_ignored_start;
        int k, n;
        push_a_frame();
        a_ready = 1'b1; a_hs = 0; a_done_cnt = 0;
        @(negedge clk); a_start = 1'b1;
        @(posedge clk); #1; k = cyc; a_start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        n = 0;
        while (a_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        vectors++;
        if (a_last_hs != k + 20 || a_hs != 4 || qa.size() != 0) begin
            miscompares++;
            $display("FAIL start_while_busy: got last_hs=k+%0d hs=%0d left=%0d, want k+20 4 0",
                     a_last_hs - k, a_hs, qa.size());
        end
        @(negedge clk);
        a_start = 1'b1; a_abort = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0; a_abort = 1'b0;
        vectors++;
        if (a_busy !== 1'b0 || a_row_sel !== 2'b00) begin
            miscompares++;
            $display("FAIL start_abort_idle: got busy=%b rs=%b, want 0 00", a_busy, a_row_sel);
        end
        repeat (8) @(negedge clk);
        vectors++;
        if (a_busy !== 1'b0 || a_hs != 4 || a_done_cnt != 1) begin
            miscompares++;
            $display("FAIL start_abort_quiet: got busy=%b hs=%0d pulses=%0d, want 0 4 1",
                     a_busy, a_hs, a_done_cnt);
        end
    endtask

    task automatic test_sweep_3x1;
        int k, n;
        qb.push_back(mk_b(3'b001, 8'h00, 1'b1, 1'b1, 1'b0));
        qb.push_back(mk_b(3'b010, 8'h10, 1'b0, 1'b1, 1'b0));
        qb.push_back(mk_b(3'b100, 8'h20, 1'b0, 1'b1, 1'b1));
        b_ready = 1'b1; b_hs = 0; b_done_cnt = 0;
        @(negedge clk); b_start = 1'b1;
        @(posedge clk); #1; k = cyc; b_start = 1'b0;
        vectors++;
        if (b_row_sel !== 3'b001) begin
            miscompares++;
            $display("FAIL sweep_row_sel: got %b, want 001", b_row_sel);
        end
        n = 0;
        while (b_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        vectors++;
        if (b_last_hs != k + 12 || b_hs != 3 || qb.size() != 0 || b_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL sweep_frame_end: got last_hs=k+%0d hs=%0d left=%0d busy=%b, want k+12 3 0 0",
                     b_last_hs - k, b_hs, qb.size(), b_busy);
        end
        @(negedge clk);
        vectors++;
        if (b_done !== 1'b0 || b_done_cnt != 1 || b_row_sel !== 3'b000) begin
            miscompares++;
            $display("FAIL sweep_done_pulse: got done=%b pulses=%0d rs=%b, want 0 1 000",
                     b_done, b_done_cnt, b_row_sel);
        end
    endtask

    initial begin
        fork
            a_monitor();
            b_monitor();
        join_none
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_ignored_start();
        test_sweep_3x1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want bench to finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/readout_sequencer.md
Name: readout_sequencer

Overview:
Sequences the read phase of the pixel array once conversion has finished. It walks the rows (one-hot row select) and the columns (binary column index). It waits programmable settle times, samples the selected pixel's digital value and streams it out over a valid/ready interface with frame and line markers. The sensor state controller triggers it with a start pulse, and it signals frame completion with a done pulse.

Parameters:
PIXEL_ARRAY_HEIGHT, 2, number of rows; one-hot row select width
PIXEL_ARRAY_WIDTH, 2, number of columns
PIXEL_BITS, 8, width of pixel value (matches dRamp width)
COL_BITS, 1, column index width; must be >= max(1, clog2(PIXEL_ARRAY_WIDTH))
ROW_SETTLE, 5, cycles waited after a row change before sampling (>=1)
COL_SETTLE, 1, cycles waited after a column change within a row before sampling (>=1)
SETTLE_BITS, 8, settle counter width; both settle values must fit

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  begin frame readout; sampled only in IDLE
abort  input  1  synchronous abort of a frame in progress
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse after the last pixel handshake
p_row_select  output  PIXEL_ARRAY_HEIGHT  one-hot row select; 0 in IDLE
p_col_index  output  COL_BITS  selected column; 0 in IDLE
p_pixel_data  input  PIXEL_BITS  value of the selected pixel
out_data  output  PIXEL_BITS  sampled pixel
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts when high with out_valid
out_sof  output  1  qualifies first pixel of frame (row 0, col 0)
out_eol  output  1  qualifies last column of a row
out_eof  output  1  qualifies last pixel of frame

Behaviour:
- Reset (reset low, asynchronous): state IDLE; all outputs 0; row and column counters 0; settle counter 0.
- States: IDLE, SETTLE, SAMPLE, OUTPUT.
- IDLE, start=1 at an edge:
  - Next state SETTLE, row=0, col=0, p_row_select=1 (bit 0), settle target ROW_SETTLE.
  - start while not IDLE is ignored.
- SETTLE:
  - Settle counter counts from 0.
  - The counter leaves SETTLE for SAMPLE at the edge where it equals target-1, so SETTLE lasts exactly target cycles.
  - p_row_select and p_col_index are held stable.
- SAMPLE (1 cycle):
  - At its ending edge, out_data <= p_pixel_data and out_valid <= 1.
  - At the same edge, out_sof, out_eol and out_eof are registered from row/col.
  - Next state OUTPUT.
- OUTPUT:
  - out_data and the flags are held stable while out_valid=1 and out_ready=0, with no cycle limit.
  - On an edge with out_ready=1, out_valid <= 0 and the flags <= 0, then:
    - last column, last row: next state IDLE, done=1 for 1 cycle, p_row_select <= 0, p_col_index <= 0.
    - last column, not last row: row+1, p_row_select shifts left by one, col=0, SETTLE with target ROW_SETTLE.
    - otherwise: col+1, SETTLE with target COL_SETTLE.
- out_ready is don't-care outside OUTPUT. out_valid never rises without a SAMPLE.
- Latency and throughput:
  - First out_valid is high ROW_SETTLE+1 cycles after the start edge.
  - With out_ready tied high, the final handshake occurs H*(ROW_SETTLE+2) + H*(W-1)*(COL_SETTLE+2) edges after the start edge.
  - done is high in the following cycle; busy falls in that same cycle.
- abort=1 at an edge in any non-IDLE state:
  - Next state IDLE; all outputs return to reset values.
  - done is not pulsed.
  - out_valid drops even if no handshake occurred (the only permitted valid withdrawal).
- abort in IDLE has no effect. start and abort together in IDLE: abort wins and the block stays IDLE.
- PIXEL_ARRAY_HEIGHT=1 or PIXEL_ARRAY_WIDTH=1: out_eol is set on every pixel of a row / out_sof and out_eof coincide where applicable. No row shift occurs past the top bit.
- Reset asserted mid-frame: immediate return to reset state with no done pulse. After reset releases, the block waits for a new start.

Test Plan:
- Defaults, out_ready=1, start pulse at edge k -> p_row_select=01 after k; out_valid first high after edge k+6 with out_sof=1; 4 pixels in order (r0c0, r0c1, r1c0, r1c1); out_eol on pixels 2 and 4; out_eof on pixel 4; final handshake at edge k+20; done high exactly 1 cycle after it.
- Backpressure: hold out_ready=0 for 10 cycles on pixel r0c1 -> out_data, out_eol=1 and p_col_index=1 stay stable for all 10 cycles; no extra pixels; total frame end delayed by exactly 10 cycles.
- Data integrity: drive p_pixel_data = {row,col} pattern (0x00, 0x01, 0x10, 0x11) -> out_data matches per pixel; changing p_pixel_data during OUTPUT does not alter out_data.
- Abort during SETTLE of r1c0 -> busy=0, p_row_select=0 and out_valid=0 next cycle; done never asserts; a new start then produces a full 4-pixel frame beginning with out_sof.
- Reset low asynchronously mid-OUTPUT (between edges) -> out_valid and p_row_select go 0 immediately; start asserted while busy and start+abort in IDLE -> both ignored, with no state change.
- Parameter sweep H=3, W=1, ROW_SETTLE=2 -> p_row_select sequence 001, 010, 100; every pixel flagged out_eol; out_sof on the first pixel and out_eof on the third; frame end 12 edges after start.
